// File: rtl/trees_dma_rd_arbiter_pkg.sv
// Shared types for the DMA read arbiter: FSM states, captured request record, length clipping.
package trees_dma_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] length;
    logic [2:0]  size;
  } dma_req_t;

  function automatic logic [31:0] clip_len(input logic [31:0] len, input int unsigned max_len);
    return (len > max_len) ? 32'(max_len) : len;
  endfunction

endpackage

// File: rtl/trees_dma_rd_arbiter_if.sv
// ESP DMA read port (ctrl + chnl); master = arbiter side, slave = DMA engine side.
interface trees_dma_rd_arbiter_if;
  logic        dma_read_ctrl_ready;
  logic        dma_read_ctrl_valid;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_ctrl_data_user;
  logic        dma_read_chnl_ready;
  logic        dma_read_chnl_valid;
  logic [63:0] dma_read_chnl_data;

  modport master (
    input  dma_read_ctrl_ready,
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    output dma_read_ctrl_data_size, dma_read_ctrl_data_user,
    output dma_read_chnl_ready,
    input  dma_read_chnl_valid, dma_read_chnl_data
  );

  modport slave (
    output dma_read_ctrl_ready,
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    input  dma_read_ctrl_data_size, dma_read_ctrl_data_user,
    input  dma_read_chnl_ready,
    output dma_read_chnl_valid, dma_read_chnl_data
  );
endinterface

// File: rtl/trees_dma_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        any    = 1'b1;
        idx    = IW'((int'(ptr) + k) % N);
        onehot = N'(1) << ((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/trees_dma_rd_arbiter.sv
// Round-robin arbiter granting whole read transactions on one ESP DMA read port.
// Optional TREES_ARB_PERF_EN adds per-requester saturating wait-cycle counters (perf_wait).
module trees_dma_rd_arbiter
  import trees_dma_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MAX_LEN = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_ctrl_valid,
  output logic [N_REQ-1:0]     req_ctrl_ready,
  input  logic [N_REQ*32-1:0]  req_ctrl_index,
  input  logic [N_REQ*32-1:0]  req_ctrl_length,
  input  logic [N_REQ*3-1:0]   req_ctrl_size,
  output logic [N_REQ-1:0]     req_chnl_valid,
  input  logic [N_REQ-1:0]     req_chnl_ready,
  output logic [63:0]          req_chnl_data,
  output logic [N_REQ-1:0]     grant,
`ifdef TREES_ARB_PERF_EN
  output logic [N_REQ*32-1:0]  perf_wait,
`endif
  trees_dma_rd_arbiter_if.master dma
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LEN) + 1;

  arb_state_e       state;
  dma_req_t         cur;
  logic             ctrl_valid_q;
  logic [IW-1:0]    rr_ptr, win_idx, pick_idx, next_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;
  logic [CW-1:0]    beat_cnt;
  logic             beat_acc, last_beat;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req    (req_ctrl_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr  = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign last_beat = ({{(32-CW){1'b0}}, beat_cnt} == cur.length - 32'd1);

  // Data path is a straight wire to the owner; nothing is buffered here.
  assign dma.dma_read_chnl_ready = (state == DATA) && req_chnl_ready[win_idx];
  assign beat_acc                = dma.dma_read_chnl_ready && dma.dma_read_chnl_valid;
  assign req_chnl_valid          = (state == DATA && dma.dma_read_chnl_valid) ? grant : '0;
  assign req_chnl_data           = (state == DATA) ? dma.dma_read_chnl_data : '0;

  assign dma.dma_read_ctrl_valid       = ctrl_valid_q;
  assign dma.dma_read_ctrl_data_index  = cur.index;
  assign dma.dma_read_ctrl_data_length = cur.length;
  assign dma.dma_read_ctrl_data_size   = cur.size;
  assign dma.dma_read_ctrl_data_user   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB;
      cur            <= '0;
      ctrl_valid_q   <= 1'b0;
      rr_ptr         <= '0;
      win_idx        <= '0;
      beat_cnt       <= '0;
      grant          <= '0;
      req_ctrl_ready <= '0;
    end else begin
      req_ctrl_ready <= '0;
      case (state)
        ARB: begin
          if (pick_any) begin
            win_idx        <= pick_idx;
            grant          <= pick_oh;
            req_ctrl_ready <= pick_oh;
            cur.index      <= req_ctrl_index[int'(pick_idx)*32 +: 32];
            cur.length     <= clip_len(req_ctrl_length[int'(pick_idx)*32 +: 32], MAX_LEN);
            cur.size       <= req_ctrl_size[int'(pick_idx)*3 +: 3];
            ctrl_valid_q   <= 1'b1;
            beat_cnt       <= '0;
            state          <= CTRL;
          end
        end
        CTRL: begin
          if (dma.dma_read_ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
            // A zero-length read still rotates priority so it cannot hog the port.
            if (cur.length == '0) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= ARB;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef TREES_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wait <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ctrl_valid[i] && !grant[i] && perf_wait[i*32 +: 32] != 32'hFFFF_FFFF)
          perf_wait[i*32 +: 32] <= perf_wait[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trees_dma_rd_arbiter.sv
// Scoreboard bench for trees_dma_rd_arbiter: directed transactions, DMA and requester models, monitor.
module tb_trees_dma_rd_arbiter;
  import trees_dma_pkg::*;

  localparam int N  = 3;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_ctrl_valid, req_ctrl_ready, req_chnl_valid, req_chnl_ready, grant;
  logic [N*32-1:0] req_ctrl_index, req_ctrl_length;
  logic [N*3-1:0]  req_ctrl_size;
  logic [63:0]     req_chnl_data;
`ifdef TREES_ARB_PERF_EN
  logic [N*32-1:0] perf_wait;
`endif

  trees_dma_rd_arbiter_if dma_if ();

  trees_dma_rd_arbiter #(.N_REQ(N), .MAX_LEN(ML)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_ctrl_valid  (req_ctrl_valid),
    .req_ctrl_ready  (req_ctrl_ready),
    .req_ctrl_index  (req_ctrl_index),
    .req_ctrl_length (req_ctrl_length),
    .req_ctrl_size   (req_ctrl_size),
    .req_chnl_valid  (req_chnl_valid),
    .req_chnl_ready  (req_chnl_ready),
    .req_chnl_data   (req_chnl_data),
    .grant           (grant),
`ifdef TREES_ARB_PERF_EN
    .perf_wait       (perf_wait),
`endif
    .dma             (dma_if)
  );

  typedef struct {int r; logic [31:0] idx; logic [31:0] len; logic [2:0] size; bit gap;} ctrl_exp_t;
  typedef struct {int r; logic [63:0] data; bit last;} beat_exp_t;

  ctrl_exp_t ctrl_q[$];
  beat_exp_t beat_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, last_end = -100, beats_seen = 0;
  int rem_req[N];
  bit tog = 1'b0;

  function automatic logic [N-1:0] oh(int r);
    return N'(1) << r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int r, logic [31:0] idx, logic [31:0] len, logic [2:0] size, int n);
    req_ctrl_index[r*32 +: 32]  = idx;
    req_ctrl_length[r*32 +: 32] = len;
    req_ctrl_size[r*3 +: 3]     = size;
    rem_req[r]                  = n;
    req_ctrl_valid[r]           = 1'b1;
  endtask

  // Expected ctrl handshake plus nb data beats (nb < 0: the full clipped length).
  task automatic exp_txn(int r, logic [31:0] idx, logic [31:0] len, logic [2:0] size, bit gap, int nb);
    ctrl_exp_t c;
    beat_exp_t b;
    int        eff;
    eff = (len > ML) ? ML : int'(len);
    c.r = r; c.idx = idx; c.len = 32'(eff); c.size = size; c.gap = gap;
    ctrl_q.push_back(c);
    if (nb < 0) nb = eff;
    for (int k = 0; k < nb; k++) begin
      b.r = r; b.data = {idx, 32'(k)}; b.last = (k == eff - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic wait_idle(string name, int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      done = ctrl_q.size() == 0 && beat_q.size() == 0 && grant == '0 &&
             req_ctrl_valid == '0 && !dma_if.dma_read_ctrl_valid;
      if (!done) step();
    end
    chk({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Monitor / scoreboard.
  ctrl_exp_t mc;
  beat_exp_t mb;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (dma_if.dma_read_ctrl_valid && dma_if.dma_read_ctrl_ready) begin
        if (ctrl_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ctrl: got index 0x%0h expected no request", dma_if.dma_read_ctrl_data_index);
        end else begin
          mc = ctrl_q.pop_front();
          chk("ctrl_grant", 64'(grant), 64'(oh(mc.r)));
          chk("ctrl_index", 64'(dma_if.dma_read_ctrl_data_index), 64'(mc.idx));
          chk("ctrl_length", 64'(dma_if.dma_read_ctrl_data_length), 64'(mc.len));
          chk("ctrl_size", 64'(dma_if.dma_read_ctrl_data_size), 64'(mc.size));
          chk("ctrl_user", 64'(dma_if.dma_read_ctrl_data_user), 64'd0);
          if (mc.gap) chk("arb_gap", 64'(cyc - last_end), 64'd2);
          if (mc.len == 0) last_end = cyc;
        end
      end
      if (dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready) begin
        beats_seen++;
        if (beat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got data 0x%0h expected no beat", req_chnl_data);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_owner", 64'(req_chnl_valid), 64'(oh(mb.r)));
          chk("beat_data", req_chnl_data, mb.data);
          if (mb.last) last_end = cyc;
        end
      end
    end
  end

  // DMA engine model: after a ctrl handshake, stream `length` beats of {index, beat}.
  initial begin
    bit          c_hs, d_hs;
    logic [31:0] lenv, idxv, base;
    int          rem, k;
    rem = 0; k = 0; base = '0;
    forever begin
      @(negedge clk);
      c_hs = dma_if.dma_read_ctrl_valid && dma_if.dma_read_ctrl_ready;
      d_hs = dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready;
      lenv = dma_if.dma_read_ctrl_data_length;
      idxv = dma_if.dma_read_ctrl_data_index;
      @(posedge clk);
      #1;
      if (rst) begin
        rem = 0;
      end else begin
        if (d_hs && rem > 0) begin rem--; k++; end
        if (c_hs) begin rem = int'(lenv); k = 0; base = idxv; end
      end
      dma_if.dma_read_chnl_valid = (rem > 0);
      dma_if.dma_read_chnl_data  = {base, 32'(k)};
    end
  end

  // Requesters: drop valid after the last accepted request, otherwise keep re-requesting.
  initial begin
    logic [N-1:0] rdy;
    forever begin
      @(negedge clk);
      rdy = req_ctrl_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (rdy[r]) begin
          if (rem_req[r] > 0) rem_req[r]--;
          if (rem_req[r] == 0) req_ctrl_valid[r] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) req_chnl_ready = ~req_chnl_ready;
      else     req_chnl_ready = '1;
    end
  end

  initial begin
    int b0, mir_n, mir_bad;
    req_ctrl_valid  = '0;
    req_ctrl_index  = '0;
    req_ctrl_length = '0;
    req_ctrl_size   = '0;
    req_chnl_ready  = '1;
    for (int r = 0; r < N; r++) rem_req[r] = 0;
    dma_if.dma_read_ctrl_ready = 1'b1;
    dma_if.dma_read_chnl_valid = 1'b0;
    dma_if.dma_read_chnl_data  = '0;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_req_ctrl_ready", 64'(req_ctrl_ready), 64'd0);
    chk("rst_req_chnl_valid", 64'(req_chnl_valid), 64'd0);
    chk("rst_ctrl_valid", 64'(dma_if.dma_read_ctrl_valid), 64'd0);
    chk("rst_chnl_ready", 64'(dma_if.dma_read_chnl_ready), 64'd0);
    chk("rst_ctrl_length", 64'(dma_if.dma_read_ctrl_data_length), 64'd0);

    // 1: single requester, ctrl held stable while the DMA stalls
    dma_if.dma_read_ctrl_ready = 1'b0;
    issue(0, 32'h100, 32'd4, DMA_SIZE_64, 1);
    exp_txn(0, 32'h100, 32'd4, DMA_SIZE_64, 1'b0, -1);
    repeat (4) step();
    chk("t1_hold_valid", 64'(dma_if.dma_read_ctrl_valid), 64'd1);
    chk("t1_hold_index", 64'(dma_if.dma_read_ctrl_data_index), 64'h100);
    chk("t1_hold_grant", 64'(grant), 64'(oh(0)));
    dma_if.dma_read_ctrl_ready = 1'b1;
    wait_idle("t1", 60);
    chk("t1_grant_released", 64'(grant), 64'd0);

    // 2: two simultaneous requests right after reset
    pulse_rst();
    issue(0, 32'h200, 32'd2, DMA_SIZE_64, 1);
    issue(1, 32'h300, 32'd2, DMA_SIZE_64, 1);
    exp_txn(0, 32'h200, 32'd2, DMA_SIZE_64, 1'b0, -1);
    exp_txn(1, 32'h300, 32'd2, DMA_SIZE_64, 1'b1, -1);
    wait_idle("t2", 60);

    // 3: req0 re-requests continuously, req1 pending twice -> 0,1,0,1
    issue(0, 32'h400, 32'd3, DMA_SIZE_64, 2);
    issue(1, 32'h500, 32'd1, DMA_SIZE_64, 2);
    exp_txn(0, 32'h400, 32'd3, DMA_SIZE_64, 1'b0, -1);
    exp_txn(1, 32'h500, 32'd1, DMA_SIZE_64, 1'b1, -1);
    exp_txn(0, 32'h400, 32'd3, DMA_SIZE_64, 1'b1, -1);
    exp_txn(1, 32'h500, 32'd1, DMA_SIZE_64, 1'b1, -1);
    wait_idle("t3", 100);

    // 4: toggling requester ready over an 8-beat burst
    b0 = beats_seen; mir_n = 0; mir_bad = 0;
    tog = 1'b1;
    issue(1, 32'h600, 32'd8, DMA_SIZE_64, 1);
    exp_txn(1, 32'h600, 32'd8, DMA_SIZE_64, 1'b0, -1);
    for (int i = 0; i < 100 && (beats_seen - b0) < 8; i++) begin
      @(negedge clk);
      if (dma_if.dma_read_chnl_valid) begin
        mir_n++;
        if (dma_if.dma_read_chnl_ready !== req_chnl_ready[1]) mir_bad++;
      end
    end
    tog = 1'b0;
    step();
    wait_idle("t4", 60);
    chk("t4_mirror_bad", 64'(mir_bad), 64'd0);
    chk("t4_beats", 64'(beats_seen - b0), 64'd8);

    // 4b: over-long request clipped to MAX_LEN, odd size forwarded
    b0 = beats_seen;
    issue(2, 32'h700, 32'd20, 3'b010, 1);
    exp_txn(2, 32'h700, 32'd20, 3'b010, 1'b0, -1);
    wait_idle("t4b", 80);
    chk("t4b_beats", 64'(beats_seen - b0), 64'(ML));

    // 5: zero length ctrl-only transaction, next grant follows
    issue(0, 32'h800, 32'd0, DMA_SIZE_64, 1);
    issue(1, 32'h900, 32'd2, DMA_SIZE_64, 1);
    exp_txn(0, 32'h800, 32'd0, DMA_SIZE_64, 1'b0, -1);
    exp_txn(1, 32'h900, 32'd2, DMA_SIZE_64, 1'b1, -1);
    wait_idle("t5", 60);

    // 6: reset on the third beat of an 8-beat burst
    b0 = beats_seen;
    issue(0, 32'hA00, 32'd8, DMA_SIZE_64, 1);
    exp_txn(0, 32'hA00, 32'd8, DMA_SIZE_64, 1'b0, 3);
    for (int i = 0; i < 60 && (beats_seen - b0) < 3; i++) step();
    rst = 1'b1;
    req_ctrl_valid[0] = 1'b0;
    rem_req[0] = 0;
    @(negedge clk);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_req_chnl_valid", 64'(req_chnl_valid), 64'd0);
    chk("t6_ctrl_valid", 64'(dma_if.dma_read_ctrl_valid), 64'd0);
    chk("t6_chnl_ready", 64'(dma_if.dma_read_chnl_ready), 64'd0);
    chk("t6_ctrl_index", 64'(dma_if.dma_read_ctrl_data_index), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_partial_beats", 64'(beats_seen - b0), 64'd3);
    issue(1, 32'hB00, 32'd2, DMA_SIZE_64, 1);
    exp_txn(1, 32'hB00, 32'd2, DMA_SIZE_64, 1'b0, -1);
    wait_idle("t6", 60);

`ifdef TREES_ARB_PERF_EN
    // 7: req1 waits through req0's 4-beat burst
    pulse_rst();
    issue(0, 32'hC00, 32'd4, DMA_SIZE_64, 1);
    issue(1, 32'hD00, 32'd1, DMA_SIZE_64, 1);
    exp_txn(0, 32'hC00, 32'd4, DMA_SIZE_64, 1'b0, -1);
    exp_txn(1, 32'hD00, 32'd1, DMA_SIZE_64, 1'b1, -1);
    wait_idle("t7", 60);
    chk("t7_perf_wait0", 64'(perf_wait[31:0]), 64'd1);
    chk("t7_perf_wait1", 64'(perf_wait[63:32]), 64'd7);
`endif

    repeat (3) step();
    chk("end_ctrl_q_empty", 64'(ctrl_q.size()), 64'd0);
    chk("end_beat_q_empty", 64'(beat_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
